// File: rtl/vga_timing_gen.sv
// 640x480 raster timing: pixel-rate divider, H/V counters, registered sync/blank decode.
// Defining VGA_SYNC_DELAY_EN delays HS/VS/BLANK_N/frame_clk by one pixel period.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_en,
    output logic       VGA_CLK,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       frame_clk,
    output logic       line_start,
    output logic       frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div;
    logic [9:0]       x_next, y_next;
    logic             x_wrap, y_wrap;
    logic             hs_next, vs_next, blank_n_next;
    logic             hs_q, vs_q, blank_n_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            div      <= '0;
            pixel_en <= 1'b0;
            VGA_CLK  <= 1'b0;
        end else begin
            div      <= (div == DIV_LAST) ? '0 : div + 1'b1;
            pixel_en <= (div == DIV_LAST);
            VGA_CLK  <= (div >= DIV_HALF);
        end
    end

    always_comb begin
        x_wrap = (DrawX == X_LAST);
        y_wrap = (DrawY == Y_LAST);
        x_next = DrawX;
        y_next = DrawY;
        if (pixel_en) begin
            x_next = x_wrap ? '0 : DrawX + 10'd1;
            if (x_wrap)
                y_next = y_wrap ? '0 : DrawY + 10'd1;
        end
    end

    // Decode from the next coordinates so the registered syncs change on the same edge as DrawX/DrawY.
    assign hs_next      = !((x_next >= HS_START) && (x_next < HS_END));
    assign vs_next      = !((y_next >= VS_START) && (y_next < VS_END));
    assign blank_n_next = (x_next < X_VIS) && (y_next < Y_VIS);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            blank_n_q   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            DrawX       <= x_next;
            DrawY       <= y_next;
            hs_q        <= hs_next;
            vs_q        <= vs_next;
            blank_n_q   <= blank_n_next;
            line_start  <= pixel_en && x_wrap;
            frame_start <= pixel_en && x_wrap && y_wrap;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hs_d, vs_d, blank_n_d;

    // Captures the decode of the pixel being left, i.e. one pixel behind the counters.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hs_d      <= 1'b1;
            vs_d      <= 1'b1;
            blank_n_d <= 1'b0;
        end else if (pixel_en) begin
            hs_d      <= hs_q;
            vs_d      <= vs_q;
            blank_n_d <= blank_n_q;
        end
    end

    assign VGA_HS      = hs_d;
    assign VGA_VS      = vs_d;
    assign VGA_BLANK_N = blank_n_d;
`else
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
`endif

    assign frame_clk  = VGA_VS;
    assign VGA_SYNC_N = 1'b0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance, a tiny-frame instance for frame checks, and a CLK_DIV=4 instance.
module tb_vga_timing_gen;
`ifdef VGA_SYNC_DELAY_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // default instance
    logic       pe, vclk, hs, vs, bn, sn, fclk, ls, fs;
    logic [9:0] dx, dy;
    // tiny frame instance: 15 x 10, sync lines 7..8
    logic       t_pe, t_vclk, t_hs, t_vs, t_bn, t_sn, t_fclk, t_ls, t_fs;
    logic [9:0] t_x, t_y;
    // divide-by-4 instance
    logic       d_pe, d_vclk, d_hs, d_vs, d_bn, d_sn, d_fclk, d_ls, d_fs;
    logic [9:0] d_x, d_y;

    vga_timing_gen u_dut (
        .Clk(clk), .Reset(rst_n), .pixel_en(pe), .VGA_CLK(vclk), .DrawX(dx), .DrawY(dy),
        .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(bn), .VGA_SYNC_N(sn), .frame_clk(fclk),
        .line_start(ls), .frame_start(fs));

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(2)
    ) u_tiny (
        .Clk(clk), .Reset(rst_n), .pixel_en(t_pe), .VGA_CLK(t_vclk), .DrawX(t_x), .DrawY(t_y),
        .VGA_HS(t_hs), .VGA_VS(t_vs), .VGA_BLANK_N(t_bn), .VGA_SYNC_N(t_sn), .frame_clk(t_fclk),
        .line_start(t_ls), .frame_start(t_fs));

    vga_timing_gen #(.CLK_DIV(4)) u_div4 (
        .Clk(clk), .Reset(rst_n), .pixel_en(d_pe), .VGA_CLK(d_vclk), .DrawX(d_x), .DrawY(d_y),
        .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_BLANK_N(d_bn), .VGA_SYNC_N(d_sn), .frame_clk(d_fclk),
        .line_start(d_ls), .frame_start(d_fs));

    typedef struct {
        int   x;
        logic hs;
        logic blank_n;
        int   y;
    } vec_t;

    vec_t tbl [0:8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic wait_x(input int x, input string name);
        int n = 0;
        while (dx != 10'(x) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk({name, "_timeout"}, 32'(dx), 32'(x));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_x"}, 32'(dx), 0);
        chk({tag, "_y"}, 32'(dy), 0);
        chk({tag, "_hs"}, 32'(hs), 1);
        chk({tag, "_vs"}, 32'(vs), 1);
        chk({tag, "_fclk"}, 32'(fclk), 1);
        chk({tag, "_blank_n"}, 32'(bn), 0);
        chk({tag, "_pixel_en"}, 32'(pe), 0);
        chk({tag, "_vga_clk"}, 32'(vclk), 0);
        chk({tag, "_line_start"}, 32'(ls), 0);
        chk({tag, "_frame_start"}, 32'(fs), 0);
        chk({tag, "_sync_n"}, 32'(sn), 0);
    endtask

    initial begin
        int t0, n, hi, lo, vs_low, bad, curx, cury, prevy, fs_seen;
        logic have_prev, exp_vs;

        tbl[0] = '{1,   1'b1, 1'b1, 0};
        tbl[1] = '{639, 1'b1, 1'b1, 0};
        tbl[2] = '{640, 1'b1, 1'b0, 0};
        tbl[3] = '{655, 1'b1, 1'b0, 0};
        tbl[4] = '{656, 1'b0, 1'b0, 0};
        tbl[5] = '{700, 1'b0, 1'b0, 0};
        tbl[6] = '{751, 1'b0, 1'b0, 0};
        tbl[7] = '{752, 1'b1, 1'b0, 0};
        tbl[8] = '{798, 1'b1, 1'b0, 0};

        // reset and first pixel strobe
        repeat (5) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel1_pixel_en", 32'(pe), 0);
        chk("rel1_x", 32'(dx), 0);
        @(negedge clk);
        chk("rel2_pixel_en", 32'(pe), 1);
        chk("rel2_x", 32'(dx), 0);
        @(negedge clk);
        chk("rel3_pixel_en", 32'(pe), 0);
        chk("rel3_x", 32'(dx), 1);
        chk("rel3_y", 32'(dy), 0);

        // first line, checked at x + sync delay so outputs describe tbl[i].x
        for (int i = 0; i < 9; i++) begin
            wait_x(tbl[i].x + DLY, $sformatf("line_x%0d", tbl[i].x));
            chk($sformatf("hs_x%0d", tbl[i].x), 32'(hs), 32'(tbl[i].hs));
            chk($sformatf("blank_n_x%0d", tbl[i].x), 32'(bn), 32'(tbl[i].blank_n));
            chk($sformatf("y_x%0d", tbl[i].x), 32'(dy), 32'(tbl[i].y));
        end

        // horizontal wrap and line period
        wait_x(799, "x799");
        chk("x799_line_start", 32'(ls), 0);
        wait_x(0, "wrap");
        chk("wrap_line_start", 32'(ls), 1);
        chk("wrap_y", 32'(dy), 1);
        chk("wrap_frame_start", 32'(fs), 0);
        t0 = cyc;
        @(negedge clk);
        chk("wrap_line_start_width", 32'(ls), 0);
        n = 0;
        while (!ls && n < 4000) begin @(negedge clk); n++; end
        chk("line_period", 32'(cyc - t0), 1600);
        chk("line2_y", 32'(dy), 2);

        // tiny frame: period, VS window, wrap from last coordinate
        n = 0;
        while (!t_fs && n < 2000) begin @(negedge clk); n++; end
        chk("tiny_first_fs_found", 32'(t_fs), 1);
        t0 = cyc;
        curx = int'(t_x); cury = int'(t_y); prevy = 0;
        have_prev = 1'b0; vs_low = 0; bad = 0;
        @(negedge clk);
        chk("tiny_fs_width", 32'(t_fs), 0);
        n = 0;
        while (!t_fs && n < 2000) begin
            if (int'(t_x) != curx || int'(t_y) != cury) begin
                prevy = cury;
                curx = int'(t_x); cury = int'(t_y);
                have_prev = 1'b1;
            end
            if (!t_vs) vs_low++;
`ifdef VGA_SYNC_DELAY_EN
            exp_vs = !(prevy >= 7 && prevy <= 8);
            if (have_prev && t_vs !== exp_vs) bad++;
`else
            exp_vs = !(cury >= 7 && cury <= 8);
            if (t_vs !== exp_vs) bad++;
`endif
            if (t_fclk !== t_vs) bad++;
            @(negedge clk);
            n++;
        end
        chk("tiny_frame_period", 32'(cyc - t0), 300);
        chk("tiny_vs_low_cycles", 32'(vs_low), 60);
        chk("tiny_vs_window_errs", 32'(bad), 0);
        chk("tiny_last_x", 32'(curx), 14);
        chk("tiny_last_y", 32'(cury), 9);
        chk("tiny_wrap_x", 32'(t_x), 0);
        chk("tiny_wrap_y", 32'(t_y), 0);
        chk("tiny_fs_implies_ls", 32'(t_ls), 1);

        // divide-by-4: pixel clock duty and line period
        n = 0;
        while (d_vclk !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        while (d_vclk !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        hi = 0;
        while (d_vclk === 1'b1 && hi < 20) begin hi++; @(negedge clk); end
        lo = 0;
        while (d_vclk === 1'b0 && lo < 20) begin lo++; @(negedge clk); end
        chk("div4_vclk_high", 32'(hi), 2);
        chk("div4_vclk_low", 32'(lo), 2);
        n = 0;
        while (!d_ls && n < 4000) begin @(negedge clk); n++; end
        t0 = cyc;
        @(negedge clk);
        n = 0;
        while (!d_ls && n < 4000) begin @(negedge clk); n++; end
        chk("div4_line_period", 32'(cyc - t0), 3200);

        // mid-frame asynchronous reset
        n = 0;
        while (!(dx == 10'd300 && dy != 10'd0) && n < 5000) begin @(negedge clk); n++; end
        chk("mid_reached", 32'(dx), 300);
        #1 rst_n = 1'b0;
        #1 chk_reset("async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fs_seen = 0;
        @(negedge clk);
        fs_seen += int'(fs);
        @(negedge clk);
        fs_seen += int'(fs);
        chk("resume_pixel_en", 32'(pe), 1);
        chk("resume_hs", 32'(hs), 1);
        chk("resume_vs", 32'(vs), 1);
        @(negedge clk);
        fs_seen += int'(fs);
        chk("resume_x", 32'(dx), 1);
        chk("resume_y", 32'(dy), 0);
        chk("resume_no_frame_start", 32'(fs_seen), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator that produces the pixel coordinates and VGA sync/blank signals consumed by the color mapper and sprite logic. It divides the system clock down to a pixel rate and scans horizontal and vertical counters through a standard 640x480 frame. It drives `DrawX`/`DrawY`, the VGA control pins, and the per-frame tick used as `frame_clk` by motion and animation logic. It sits between the board clock and the color mapper; the color mapper returns RGB for each coordinate.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `CLK_DIV`, 2, Clk cycles per pixel (≥2, even)

Ports:
- `Clk` in 1: system clock; single clock domain.
- `Reset` in 1: asynchronous, active-low reset.
- `pixel_en` out 1: one-Clk-cycle strobe, once per pixel period.
- `VGA_CLK` out 1: pixel clock to DAC, 50% duty.
- `DrawX` out 10: current horizontal count, 0..H_TOTAL-1.
- `DrawY` out 10: current vertical count, 0..V_TOTAL-1.
- `VGA_HS` out 1: horizontal sync, active-low.
- `VGA_VS` out 1: vertical sync, active-low.
- `VGA_BLANK_N` out 1: high only inside the visible area.
- `VGA_SYNC_N` out 1: tied 0.
- `frame_clk` out 1: equals `VGA_VS`; its rising edge marks the end of vertical sync.
- `line_start` out 1: one-Clk pulse when `DrawX` wraps to 0.
- `frame_start` out 1: one-Clk pulse when (`DrawX`,`DrawY`) wraps to (0,0).

## Operation
- H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525). Both must be ≤1024.
- **Divider**
  - `div` counts 0..CLK_DIV-1 and wraps.
  - `pixel_en` is registered high in the cycle in which `div`==CLK_DIV-1.
  - `VGA_CLK` is registered high while `div` ≥ CLK_DIV/2.
- **Horizontal counter** `DrawX`: on `pixel_en`, increment; at H_TOTAL-1, wrap to 0.
- **Vertical counter** `DrawY`: increments only on the same `pixel_en` in which `DrawX` wraps; at V_TOTAL-1, wraps to 0.
- **Sync and blank (registered, decoded from the next counter values so they align with `DrawX`/`DrawY`)**
  - `VGA_HS` is 0 iff H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - `VGA_VS` is 0 iff V_VISIBLE+V_FRONT ≤ y < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - `VGA_BLANK_N` is 1 iff x < H_VISIBLE and y < V_VISIBLE.
- **Line and frame pulses**: `line_start` and `frame_start` are asserted in the Clk cycle in which the wrap becomes visible on the outputs; `frame_start` implies `line_start`.
- **Reset values**
  - `div`, `DrawX`, `DrawY` = 0.
  - `VGA_HS`, `VGA_VS`, `frame_clk` = 1.
  - `VGA_BLANK_N`, `pixel_en`, `VGA_CLK`, `line_start`, `frame_start` = 0.
- **Reset mid-frame**: all state returns to the reset values asynchronously. After release, the scan restarts at (0,0) with no partial sync pulse. Reset release does not produce a `frame_start`.

## Timing
- The first `pixel_en` occurs CLK_DIV Clk cycles after reset release. Each counter step occurs in the Clk cycle after a `pixel_en`.
- Each coordinate is held for exactly CLK_DIV Clk cycles.
- Line period: H_TOTAL·CLK_DIV = 1600 Clk.
- Frame period: H_TOTAL·V_TOTAL·CLK_DIV = 840 000 Clk.
- HS low for H_SYNC·CLK_DIV = 192 Clk per line.
- VS low for V_SYNC lines, i.e. 3200 Clk per frame.
- Latency from a counter value to its sync/blank decode: 0 cycles (same edge). With the configuration macro defined, the latency changes as described below.
- Downstream color logic is combinational on `DrawX`/`DrawY`, so RGB and sync share the same edge.

## Configuration
- `VGA_SYNC_DELAY_EN`
  - **Defined**: `VGA_HS`, `VGA_VS`, `VGA_BLANK_N` and `frame_clk` pass through one additional register stage, updated on `pixel_en`. They lag `DrawX`/`DrawY` by exactly one pixel period, to match a color mapper with a registered (one-pixel) ROM read. The delay registers reset to the same values as the undelayed outputs.
  - **Undefined**: no delay stage; the alignment given under Timing applies.
  - `line_start`/`frame_start` are never delayed.

## Test plan
- **Reset values**: hold `Reset`=0 for 5 Clk, then release. Required: all outputs at their reset values; first `pixel_en` at Clk 2 after release; `DrawX`=1 at Clk 3.
- **Horizontal sync**: run one line. Required:
  - `VGA_BLANK_N` falls when `DrawX` becomes 640.
  - `VGA_HS` falls at `DrawX`=656 and rises at `DrawX`=752.
  - `DrawX` wraps 799→0 with `line_start` pulsed for 1 Clk and `DrawY`=1.
- **Vertical sync and frame pulse**: run one full frame. Required:
  - `VGA_VS` is 0 exactly while `DrawY`∈{490,491}.
  - `frame_start` pulses once, 840 000 Clk after the first `pixel_en`.
  - `DrawY` wraps 524→0.
- **Mid-frame reset**: assert `Reset` at `DrawX`=300, `DrawY`=200. Required: outputs go to reset values in the same cycle, asynchronously, with no Clk edge needed; after release the scan resumes at (0,0).
- **Sync delay macro**: compile with `VGA_SYNC_DELAY_EN`. Required: `VGA_HS` falls when `DrawX`=657 (one pixel late), while `line_start` timing is unchanged.
- **Alternate divider**: set `CLK_DIV`=4. Required: `VGA_CLK` is high 2 Clk / low 2 Clk, and the line period is 3200 Clk.
